// File: rtl/agn_pkg.sv
// Shared types and defaults for the parabolic-pulse burst sequencer.
// The AGN_AMP_RAMP_EN build uses agn_ramp_amp for per-pulse amplitude.
package agn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    BURST = 2'd2,
    GAP   = 2'd3
  } agn_state_e;

  localparam int AGN_DIV_W = 16;
  localparam int AGN_CNT_W = 8;
  localparam int AGN_NP    = 100;

  // min(amp, pulse_num*step); a zero step disables the ramp
  function automatic logic [7:0] agn_ramp_amp(input logic [7:0]  amp,
                                              input logic [7:0]  step,
                                              input logic [15:0] pulse_num);
    logic [23:0] prod;
    prod = 24'(step) * 24'(pulse_num);
    if ((step == 8'd0) || (prod >= 24'(amp))) begin
      return amp;
    end
    return prod[7:0];
  endfunction

endpackage

// File: rtl/agn_ce_prescaler.sv
// Point-rate strobe generator: one registered strobe every div+1 enabled cycles.
// A synchronous clear parks the counter so the first strobe lands div+1 cycles after enable.
module agn_ce_prescaler
  import agn_pkg::*;
#(
  parameter int DIV_W = AGN_DIV_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             strobe
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             strobe_q, strobe_d;

  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == div) begin
        cnt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign strobe = strobe_q;

endmodule

// File: rtl/agn_burst_ctrl.sv
// Burst sequencer for the parabolic pulse generator: N pulses, G zero pulses, B times.
// Define AGN_AMP_RAMP_EN to add the amp_step input and ramp amplitude within a burst.
module agn_burst_ctrl
  import agn_pkg::*;
#(
  parameter int DIV_W = AGN_DIV_W,
  parameter int CNT_W = AGN_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic [DIV_W-1:0] div,
  input  logic [7:0]       amp,
  input  logic [CNT_W-1:0] n_pulses,
  input  logic [CNT_W-1:0] n_gap,
  input  logic [CNT_W-1:0] n_bursts,
`ifdef AGN_AMP_RAMP_EN
  input  logic [7:0]       amp_step,
`endif
  input  logic             co_par,
  output logic             ce_par,
  output logic [7:0]       m_par,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] burst_idx
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  agn_state_e       state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       amp_q, amp_d;
  logic [7:0]       m_par_q, m_par_d;
  logic [CNT_W-1:0] np_m1_q, np_m1_d;
  logic [CNT_W-1:0] ng_m1_q, ng_m1_d;
  logic [CNT_W-1:0] nb_m1_q, nb_m1_d;
  logic             gap_zero_q, gap_zero_d;
  logic [CNT_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0] burst_idx_q, burst_idx_d;
  logic             stop_q, stop_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ce_strobe;
  logic             bnd;
  logic             stop_any;
  logic             to_idle;
  logic [7:0]       amp_first;
  logic [7:0]       amp_next;

`ifdef AGN_AMP_RAMP_EN
  logic [7:0] amp_step_q, amp_step_d;

  assign amp_first = agn_ramp_amp(amp_q, amp_step_q, 16'd1);
  assign amp_next  = agn_ramp_amp(amp_q, amp_step_q, 16'(pulse_cnt_q) + 16'd2);
`else
  assign amp_first = amp_q;
  assign amp_next  = amp_q;
`endif

  assign bnd      = ce_strobe & co_par;
  assign stop_any = stop_q | stop;

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    amp_d       = amp_q;
    m_par_d     = m_par_q;
    np_m1_d     = np_m1_q;
    ng_m1_d     = ng_m1_q;
    nb_m1_d     = nb_m1_q;
    gap_zero_d  = gap_zero_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_idx_d = burst_idx_q;
    stop_d      = stop_any;
    done_d      = 1'b0;
    to_idle     = 1'b0;
`ifdef AGN_AMP_RAMP_EN
    amp_step_d  = amp_step_q;
`endif

    case (state_q)
      IDLE: begin
        // start beats a simultaneous stop, so the flag never arms here
        stop_d  = 1'b0;
        m_par_d = '0;
        if (start) begin
          div_d       = div;
          amp_d       = amp;
          np_m1_d     = n_pulses - CNT_ONE;
          ng_m1_d     = n_gap - CNT_ONE;
          nb_m1_d     = n_bursts - CNT_ONE;
          gap_zero_d  = (n_gap == '0);
          pulse_cnt_d = '0;
          gap_cnt_d   = '0;
          burst_idx_d = '0;
`ifdef AGN_AMP_RAMP_EN
          amp_step_d  = amp_step;
`endif
          if ((n_pulses == '0) || (n_bursts == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = SYNC;
          end
        end
      end

      SYNC: begin
        if (bnd) begin
          if (stop_any) begin
            to_idle = 1'b1;
          end else begin
            state_d     = BURST;
            m_par_d     = amp_first;
            pulse_cnt_d = '0;
          end
        end
      end

      BURST: begin
        if (bnd) begin
          if (stop_any) begin
            to_idle = 1'b1;
          end else if (pulse_cnt_q == np_m1_q) begin
            if (burst_idx_q == nb_m1_q) begin
              to_idle = 1'b1;
              done_d  = 1'b1;
            end else if (gap_zero_q) begin
              burst_idx_d = burst_idx_q + CNT_ONE;
              pulse_cnt_d = '0;
              m_par_d     = amp_first;
            end else begin
              state_d   = GAP;
              m_par_d   = '0;
              gap_cnt_d = '0;
            end
          end else begin
            pulse_cnt_d = pulse_cnt_q + CNT_ONE;
            m_par_d     = amp_next;
          end
        end
      end

      GAP: begin
        if (bnd) begin
          if (stop_any) begin
            to_idle = 1'b1;
          end else if (gap_cnt_q == ng_m1_q) begin
            state_d     = BURST;
            m_par_d     = amp_first;
            burst_idx_d = burst_idx_q + CNT_ONE;
            pulse_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + CNT_ONE;
          end
        end
      end

      default: begin
        to_idle = 1'b1;
      end
    endcase

    if (to_idle) begin
      state_d     = IDLE;
      m_par_d     = '0;
      stop_d      = 1'b0;
      pulse_cnt_d = '0;
      gap_cnt_d   = '0;
      burst_idx_d = '0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      amp_q       <= '0;
      m_par_q     <= '0;
      np_m1_q     <= '0;
      ng_m1_q     <= '0;
      nb_m1_q     <= '0;
      gap_zero_q  <= 1'b0;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
      burst_idx_q <= '0;
      stop_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
`ifdef AGN_AMP_RAMP_EN
      amp_step_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      amp_q       <= amp_d;
      m_par_q     <= m_par_d;
      np_m1_q     <= np_m1_d;
      ng_m1_q     <= ng_m1_d;
      nb_m1_q     <= nb_m1_d;
      gap_zero_q  <= gap_zero_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_idx_q <= burst_idx_d;
      stop_q      <= stop_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
`ifdef AGN_AMP_RAMP_EN
      amp_step_q  <= amp_step_d;
`endif
    end
  end

  // Prescaler follows the next state so its strobe is already low in the first IDLE cycle
  agn_ce_prescaler #(
    .DIV_W(DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .en    (busy_d),
    .clr   (~busy_d),
    .div   (div_d),
    .strobe(ce_strobe)
  );

  assign ce_par    = ce_strobe;
  assign m_par     = m_par_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign burst_idx = burst_idx_q;

endmodule

// File: tb/tb_agn_burst_ctrl.sv
// Self-checking bench for agn_burst_ctrl with an NP-point parabolic generator model attached.
// Build with AGN_AMP_RAMP_EN defined to exercise the amplitude ramp.
`timescale 1ns/1ps
module tb_agn_burst_ctrl;
  import agn_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] div = '0;
  logic [7:0]  amp = '0;
  logic [7:0]  n_pulses = '0;
  logic [7:0]  n_gap = '0;
  logic [7:0]  n_bursts = '0;
`ifdef AGN_AMP_RAMP_EN
  logic [7:0]  amp_step = '0;
`endif
  logic        co_par;
  logic        ce_par;
  logic [7:0]  m_par;
  logic        busy;
  logic        done;
  logic [7:0]  burst_idx;

  int tests_run = 0;
  int tests_failed = 0;

  // Generator model: NP points per pulse, CO_PAR flags the last point, frozen without ce
  int   gen_pt;
  int   gen_init;
  logic gen_load = 1'b1;

  assign co_par = (gen_pt == AGN_NP - 1);

  always @(posedge clk) begin
    if (gen_load) gen_pt <= gen_init;
    else if (ce_par) gen_pt <= (gen_pt == AGN_NP - 1) ? 0 : gen_pt + 1;
  end

  always #5 clk = ~clk;

  agn_burst_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .div      (div),
    .amp      (amp),
    .n_pulses (n_pulses),
    .n_gap    (n_gap),
    .n_bursts (n_bursts),
`ifdef AGN_AMP_RAMP_EN
    .amp_step (amp_step),
`endif
    .co_par   (co_par),
    .ce_par   (ce_par),
    .m_par    (m_par),
    .busy     (busy),
    .done     (done),
    .burst_idx(burst_idx)
  );

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  function automatic int model_amp(input int a, input int s, input int k);
    int r;
    r = a;
`ifdef AGN_AMP_RAMP_EN
    if (s != 0 && (k + 1) * s < a) r = (k + 1) * s;
`else
    if (s < 0 || k < 0) r = 0;
`endif
    return r;
  endfunction

  task automatic scramble_inputs();
    div      = 16'($urandom);
    amp      = 8'($urandom);
    n_pulses = 8'($urandom);
    n_gap    = 8'($urandom);
    n_bursts = 8'($urandom);
`ifdef AGN_AMP_RAMP_EN
    amp_step = 8'($urandom);
`endif
  endtask

  // One run: model expands the config into a per-pulse (M, burst index) list
  task automatic run(input int dv, input int am, input int np, input int ng, input int nb,
                     input int st, input int stop_at, input int rst_at, input bit with_stop);
    int   exp_m[$];
    int   exp_b[$];
    int   j, cyc, end_j, limit, ce_in_pulse, ce_bad, last_ce, m_bad, done_bad, ce_cnt;
    bit   prev_bnd, fin, stop_sent, was_rst;
    logic [7:0] prev_m;

    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < np; k++) begin
        exp_m.push_back(model_amp(am, st, k));
        exp_b.push_back(b);
      end
      if (b != nb - 1) begin
        for (int g = 0; g < ng; g++) begin
          exp_m.push_back(0);
          exp_b.push_back(b);
        end
      end
    end
    end_j = (stop_at >= 0) ? stop_at + 1 : exp_m.size() + 1;

    @(negedge clk);
    div = 16'(dv); amp = 8'(am); n_pulses = 8'(np); n_gap = 8'(ng); n_bursts = 8'(nb);
`ifdef AGN_AMP_RAMP_EN
    amp_step = 8'(st);
`endif
    start = 1'b1;
    stop  = with_stop;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    scramble_inputs();

    if (np == 0 || nb == 0) begin
      @(negedge clk);
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      ce_cnt = 0;
      for (int i = 0; i < 6; i++) begin
        if (ce_par) ce_cnt++;
        @(negedge clk);
      end
      chk("zero_no_ce", ce_cnt, 0);
      chk("zero_done_width", done, 0);
      $display("[TB] run div=%0d amp=%0d n=%0d g=%0d b=%0d: empty run", dv, am, np, ng, nb);
      return;
    end

    j = 0; fin = 0; prev_bnd = 0; ce_in_pulse = 0; ce_bad = 0; last_ce = -1;
    m_bad = 0; done_bad = 0; stop_sent = 0; was_rst = 0; prev_m = '0;
    limit = (exp_m.size() + 3) * AGN_NP * (dv + 1) + 50;
    for (cyc = 1; cyc <= limit && !fin; cyc++) begin
      @(negedge clk);
      stop = 1'b0;
      if (!prev_bnd && m_par !== prev_m) m_bad++;
      prev_m = m_par;
      if (prev_bnd) begin
        j++;
        if (j >= 2) chk("pulse_len", ce_in_pulse, AGN_NP);
        ce_in_pulse = 0;
        if (j == end_j) begin
          chk("end_busy", busy, 0);
          chk("end_done", done, (stop_at < 0));
          chk("end_m_par", m_par, 0);
          chk("end_ce_par", ce_par, 0);
          fin = 1;
        end else begin
          chk("m_par", m_par, exp_m[j-1]);
          chk("burst_idx", burst_idx, exp_b[j-1]);
          chk("busy", busy, 1);
        end
      end
      if (!fin) begin
        if (done) done_bad++;
        if (ce_par) begin
          ce_in_pulse++;
          if (last_ce < 0) chk("first_ce", cyc, dv + 1);
          else if (cyc - last_ce != dv + 1) ce_bad++;
          last_ce = cyc;
        end
        prev_bnd = ce_par & co_par;
        if (ce_par && ce_in_pulse == AGN_NP / 2) begin
          if (j == stop_at && !stop_sent) begin
            stop = 1'b1;
            stop_sent = 1;
          end
          if (j == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("rst_ce_par", ce_par, 0);
            chk("rst_m_par", m_par, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_burst_idx", burst_idx, 0);
            fin = 1;
            was_rst = 1;
          end
        end
        start = ($urandom_range(63) == 0);
      end
    end
    start = 1'b0;
    chk("finished", fin, 1);
    chk("ce_spacing", ce_bad, 0);
    chk("m_only_on_bnd", m_bad, 0);
    chk("no_early_done", done_bad, 0);
    if (fin && !was_rst) begin
      @(negedge clk);
      chk("done_width", done, 0);
    end
    $display("[TB] run div=%0d amp=%0d n=%0d g=%0d b=%0d step=%0d stop_at=%0d rst_at=%0d: %0d bnd",
             dv, am, np, ng, nb, st, stop_at, rst_at, j);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    gen_init = $urandom_range(AGN_NP - 1);
    repeat (3) @(posedge clk);
    #1;
    gen_load = 1'b0;
    @(negedge clk);
    chk("reset_ce_par", ce_par, 0);
    chk("reset_m_par", m_par, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_burst_idx", burst_idx, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_ce_par", ce_par, 0);

    run(0, 200, 3, 2, 2, 0, -1, -1, 1'b0);
    run(3, 77, 2, 1, 2, 0, -1, -1, 1'b0);
    run(1, 150, 1, 0, 3, 0, -1, -1, 1'b0);
    run(0, 90, 0, 1, 2, 0, -1, -1, 1'b0);
    run(2, 90, 2, 1, 0, 0, -1, -1, 1'b0);
    run(0, 120, 3, 1, 2, 0, 2, -1, 1'b0);
    run(0, 60, 1, 0, 2, 0, -1, -1, 1'b1);
    run(0, 180, 1, 2, 2, 0, -1, 2, 1'b0);
    run(0, 180, 1, 1, 1, 0, -1, -1, 1'b0);
`ifdef AGN_AMP_RAMP_EN
    run(0, 100, 4, 0, 1, 40, -1, -1, 1'b0);
    run(0, 100, 2, 1, 2, 0, -1, -1, 1'b0);
`endif
    for (int r = 0; r < 4; r++) begin
      run($urandom_range(2), $urandom_range(255), $urandom_range(1, 3), $urandom_range(2),
          $urandom_range(1, 3), $urandom_range(255), -1, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
